// File: rtl/systolic_acc_drain.sv
// Drains a ROWS x COLS systolic accumulator grid: snapshot on start, clear the array, stream row-major.
// Optional DRAIN_REQUANT_EN: shift by REQ_SHIFT and saturate each element to signed 8 bits on the output path.
module systolic_acc_drain #(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int ACC_WIDTH = 32,
    parameter int REQ_SHIFT = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [ROWS*COLS*ACC_WIDTH-1:0] acc_in,
    output logic                           acc_clr,
    output logic                           busy,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ACC_WIDTH-1:0]           out_data,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row,
    output logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0] out_col,
    output logic                           out_last,
    output logic                           done
);

    localparam int N  = ROWS * COLS;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    if (REQ_SHIFT < 0 || REQ_SHIFT >= ACC_WIDTH) begin : g_bad_shift
        $error("REQ_SHIFT must lie in [0, ACC_WIDTH-1]");
    end

    logic [1:0]           state_q, state_d;
    logic [RW-1:0]        row_q, row_d;
    logic [CW-1:0]        col_q, col_d;
    logic                 acc_clr_q, acc_clr_d;
    logic [ACC_WIDTH-1:0] snap_q [N];
    logic [ACC_WIDTH-1:0] snap_d [N];

    logic                 take_start;
    logic                 at_last;
    logic                 hs;
    logic [IW-1:0]        sel;
    logic [ACC_WIDTH-1:0] elem;
    logic [ACC_WIDTH-1:0] data_fmt;

    assign take_start = (state_q == ST_IDLE) && start;
    assign at_last    = (row_q == ROW_MAX) && (col_q == COL_MAX);
    assign hs         = out_valid && out_ready;

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        acc_clr_d = 1'b0;
        snap_d    = snap_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_STREAM;
                    row_d     = '0;
                    col_d     = '0;
                    acc_clr_d = 1'b1;
                    for (int i = 0; i < N; i++) begin
                        snap_d[i] = acc_in[i*ACC_WIDTH +: ACC_WIDTH];
                    end
                end
            end
            ST_STREAM: begin
                if (hs) begin
                    if (at_last) begin
                        // Counters park at zero so idle index outputs read 0.
                        state_d = ST_FINISH;
                        row_d   = '0;
                        col_d   = '0;
                    end else if (col_q == COL_MAX) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                row_d   = '0;
                col_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            acc_clr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            acc_clr_q <= acc_clr_d;
        end
    end

    // Snapshot buffer is deliberately not reset; it is only read while streaming.
    always_ff @(posedge clk) begin
        snap_q <= snap_d;
    end

    assign sel  = IW'(32'(row_q) * 32'(COLS) + 32'(col_q));
    assign elem = snap_q[sel];

`ifdef DRAIN_REQUANT_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(127);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-128);

    logic signed [ACC_WIDTH-1:0] shifted;

    always_comb begin
        shifted = $signed(elem) >>> REQ_SHIFT;
        if (shifted > SAT_MAX) begin
            data_fmt = SAT_MAX;
        end else if (shifted < SAT_MIN) begin
            data_fmt = SAT_MIN;
        end else begin
            data_fmt = shifted;
        end
    end
`else
    assign data_fmt = elem;
`endif

    assign acc_clr   = acc_clr_q;
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_STREAM);
    assign done      = (state_q == ST_FINISH);
    assign out_last  = out_valid && at_last;
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign out_data  = out_valid ? data_fmt : '0;

    logic unused_take_start;
    assign unused_take_start = take_start;

endmodule

// File: doc/systolic_acc_drain.md
Name: systolic_acc_drain

Overview:
Reads back the accumulator grid of a ROWS x COLS systolic MAC array once a tile finishes, and streams the results out one element per handshake. On start it snapshots every cell's accumulator and pulses a clear to the array, so the next tile can accumulate while the drain streams. It sits between the array's acc_out bus and the result writeback path.

Parameters:
ROWS, 4, array rows
COLS, 4, array columns
ACC_WIDTH, 32, accumulator width per cell, also the out_data width
REQ_SHIFT, 0, arithmetic right-shift amount; used only when DRAIN_REQUANT_EN is defined

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  request a drain; sampled only in IDLE
acc_in  in  ROWS*COLS*ACC_WIDTH  flattened cell accumulators; cell (r,c) at [(r*COLS+c)*ACC_WIDTH +: ACC_WIDTH]
acc_clr  out  1  one-cycle clear pulse, drives the array's acc_rst
busy  out  1  high while not in IDLE
out_valid  out  1  out_data is valid
out_ready  in  1  downstream accepts
out_data  out  ACC_WIDTH  result element, signed
out_row  out  $clog2(ROWS) (min 1)  row index of out_data
out_col  out  $clog2(COLS) (min 1)  column index of out_data
out_last  out  1  marks element (ROWS-1, COLS-1)
done  out  1  one-cycle pulse after the final handshake

Behaviour:
- Reset values: state IDLE; acc_clr, busy, out_valid, out_last and done = 0; out_data, out_row and out_col = 0. The snapshot buffer is not reset.
- States: IDLE, STREAM, FINISH.
- IDLE, when start=1 at edge k:
  - snapshot all ROWS*COLS accumulators into the internal buffer
  - state becomes STREAM and row/col counters become 0,0
  - acc_clr=1 for exactly the cycle after edge k
  - out_valid=1 with element (0,0) from the cycle after edge k, so latency from start to first valid is 1 cycle
- STREAM:
  - Order is row-major: col increments and wraps at COLS-1, then row increments.
  - out_data, out_row and out_col come from the snapshot, never from the live acc_in.
  - Handshake occurs when out_valid && out_ready. Once out_valid is high, out_data, out_row, out_col and out_last stay stable until a handshake.
  - out_valid stays high continuously through STREAM, giving one element per cycle when out_ready is held high.
  - out_last=1 only while (ROWS-1, COLS-1) is presented.
  - A handshake on the last element moves the state to FINISH; out_valid drops the next cycle.
- FINISH: done=1 for one cycle, then the state returns to IDLE. Total cycles from start to done with out_ready held high: ROWS*COLS+1.
- start while busy is ignored. It is not queued and causes no second acc_clr.
- start in the same cycle as done (FINISH) is ignored. The earliest accepted start is the first IDLE cycle after done.
- rst mid-operation: the block immediately returns to IDLE with all outputs at their reset values. No acc_clr is issued and no done pulse is produced.
- ROWS=1 or COLS=1 must work: index ports are at least 1 bit wide and the counter wrap still applies.

Optional Feature:
Macro DRAIN_REQUANT_EN.
- Defined: each snapshot element is arithmetically right-shifted by REQ_SHIFT (truncating), then saturated to the signed 8-bit range [-128, 127], then sign-extended to ACC_WIDTH on out_data. This happens combinationally on the output path with no added latency. Port list is unchanged.
- Undefined: out_data is the raw snapshot value. REQ_SHIFT is ignored.

Test Plan:
- 2x2 array, acc_in = {cell(0,0)=1, (0,1)=-2, (1,0)=300, (1,1)=0x7FFFFFFF}; start pulse with out_ready=1 -> acc_clr high for exactly 1 cycle; out_valid on cycles 1-4 with data 1, -2, 300, 0x7FFFFFFF and (row,col) = 00, 01, 10, 11; out_last only on the 4th; done on cycle 5.
- Backpressure: out_ready=0 for 3 cycles on element (0,1) -> out_data=-2 and out_row/out_col held stable for those 3 cycles, no element skipped or duplicated.
- acc_in changed to all 0xFFFF after start -> streamed values still match the snapshot taken at start.
- start pulsed again mid-stream and in the done cycle -> no extra acc_clr, sequence unaffected; a start on the cycle after done is accepted.
- rst asserted while streaming element (1,0) -> next cycle busy=0, out_valid=0, done never pulses; a fresh start then streams from (0,0).
- DRAIN_REQUANT_EN defined, REQ_SHIFT=4, snapshot {1000, -5000, 64, -1} -> out_data {62, -128, 4, -1}.
